// File: rtl/draw_pkg.sv
// ============================================================================
// draw_pkg
// ----------------------------------------------------------------------------
// Shared definitions for the draw_* overlays: game-state codes, the predicate
// that says which states are rendered, and the door animation state enum.
// No ports (package).
// Revision: 1.0 - initial animated door release
// ============================================================================
`default_nettype none

package draw_pkg;

  // Game-state codes driven by the top-level game controller.
  localparam logic [3:0] TITLE  = 4'd0;
  localparam logic [3:0] MENU   = 4'd1;
  localparam logic [3:0] STAGE1 = 4'd2;
  localparam logic [3:0] CLEAR1 = 4'd3;
  localparam logic [3:0] STAGE2 = 4'd4;
  localparam logic [3:0] CLEAR2 = 4'd5;
  localparam logic [3:0] STAGE3 = 4'd6;
  localparam logic [3:0] WIN    = 4'd7;
  localparam logic [3:0] FAIL   = 4'd8;

  // Door animation states.
  typedef enum logic [1:0] {
    DOOR_CLOSED  = 2'd0,
    DOOR_OPENING = 2'd1,
    DOOR_OPEN    = 2'd2,
    DOOR_CLOSING = 2'd3
  } door_state_e;

  // Only the three play stages show the door.
  function automatic logic is_drawable(input logic [3:0] st);
    return (st == STAGE1) || (st == STAGE2) || (st == STAGE3);
  endfunction

endpackage

`default_nettype wire

// File: rtl/door_anim_fsm.sv
// ============================================================================
// door_anim_fsm
// ----------------------------------------------------------------------------
// Lock-edge detection, open/close animation state machine, per-frame hold
// counter and the optional "still locked" blink counter.
// Ports:
//   clk, rst        pixel clock, asynchronous active-high reset
//   state           game state (non-drawable states snap the door)
//   frame_tick      one-clk pulse per video frame
//   isLocked        door lock level
//   bump            one-clk pulse when the player pushes the door
//   frame_idx       displayed animation frame
//   busy            animation in progress
//   blank           door must be hidden this pixel (blink phase)
// Optional feature macro: DOOR_BLINK_EN (blink counter on locked bump).
// Revision: 1.0 - initial animated door release
// ============================================================================
`default_nettype none

module door_anim_fsm
  import draw_pkg::*;
#(
  parameter int N_FRAMES    = 4,
  parameter int FRAME_HOLD  = 3,
  parameter int BLINK_TICKS = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [3:0]                    state,
  input  logic                          frame_tick,
  input  logic                          isLocked,
  input  logic                          bump,
  output logic [$clog2(N_FRAMES)-1:0]   frame_idx,
  output logic                          busy,
  output logic                          blank
);

  localparam int FW = $clog2(N_FRAMES);
  localparam int HW = (FRAME_HOLD > 1) ? $clog2(FRAME_HOLD) : 1;
  localparam logic [FW-1:0] LAST      = FW'(N_FRAMES - 1);
  localparam logic [FW-1:0] PRE_LAST  = FW'(N_FRAMES - 2);
  localparam logic [FW-1:0] FIRST_UP  = FW'(1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(FRAME_HOLD - 1);

  door_state_e   state_q, state_d;
  logic [FW-1:0] frame_q, frame_d;
  logic [HW-1:0] hold_q, hold_d;
  logic          lk_q;
  logic          fall, rise, drawable;

  assign fall     = lk_q & ~isLocked;
  assign rise     = ~lk_q & isLocked;
  assign drawable = is_drawable(state);

  always_comb begin
    state_d = state_q;
    frame_d = frame_q;
    hold_d  = hold_q;
    if (!drawable) begin
      // Off-stage the door tracks the lock level statically so that entering
      // a stage never plays a stale animation.
      state_d = lk_q ? DOOR_CLOSED : DOOR_OPEN;
      frame_d = lk_q ? '0 : LAST;
      hold_d  = '0;
    end else begin
      case (state_q)
        DOOR_CLOSED: begin
          if (fall) begin
            state_d = DOOR_OPENING;
            hold_d  = '0;
          end
        end
        DOOR_OPENING: begin
          if (rise) begin
            // Reversal before the first step already sits at the end frame.
            state_d = (frame_q == '0) ? DOOR_CLOSED : DOOR_CLOSING;
            hold_d  = '0;
          end else if (frame_tick) begin
            if (hold_q == HOLD_LAST) begin
              hold_d  = '0;
              frame_d = frame_q + FW'(1);
              if (frame_q == PRE_LAST) state_d = DOOR_OPEN;
            end else begin
              hold_d = hold_q + HW'(1);
            end
          end
        end
        DOOR_OPEN: begin
          if (rise) begin
            state_d = DOOR_CLOSING;
            hold_d  = '0;
          end
        end
        DOOR_CLOSING: begin
          if (fall) begin
            state_d = (frame_q == LAST) ? DOOR_OPEN : DOOR_OPENING;
            hold_d  = '0;
          end else if (frame_tick) begin
            if (hold_q == HOLD_LAST) begin
              hold_d  = '0;
              frame_d = frame_q - FW'(1);
              if (frame_q == FIRST_UP) state_d = DOOR_CLOSED;
            end else begin
              hold_d = hold_q + HW'(1);
            end
          end
        end
        default: begin
          state_d = DOOR_CLOSED;
          frame_d = '0;
          hold_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= DOOR_CLOSED;
      frame_q <= '0;
      hold_q  <= '0;
      lk_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      frame_q <= frame_d;
      hold_q  <= hold_d;
      lk_q    <= isLocked;
    end
  end

  assign frame_idx = frame_q;
  assign busy      = (state_q == DOOR_OPENING) || (state_q == DOOR_CLOSING);

`ifdef DOOR_BLINK_EN
  localparam int BW = ($clog2(BLINK_TICKS + 1) < 3) ? 3 : $clog2(BLINK_TICKS + 1);

  logic [BW-1:0] blink_q, blink_d;

  always_comb begin
    blink_d = blink_q;
    if (!drawable || fall) begin
      blink_d = '0;
    end else if (bump && (state_q == DOOR_CLOSED) && isLocked) begin
      blink_d = BW'(BLINK_TICKS);
    end else if (frame_tick && (blink_q != '0)) begin
      blink_d = blink_q - BW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) blink_q <= '0;
    else     blink_q <= blink_d;
  end

  // Bit 2 gives a 4-tick on / 4-tick off flash pattern.
  assign blank = (blink_q != '0) && blink_q[2];
`else
  logic bump_unused;
  assign bump_unused = bump;
  assign blank       = 1'b0;
`endif

endmodule

`default_nettype wire

// File: rtl/draw_door_anim.sv
// ============================================================================
// draw_door_anim
// ----------------------------------------------------------------------------
// Animated door-sprite overlay. Hit-tests the current VGA pixel against the
// door rectangle and produces a registered sprite-sheet address and object
// flag; the frame shown comes from door_anim_fsm.
// Ports:
//   clk, rst          pixel clock, asynchronous active-high reset
//   state             game state
//   h_cnt, v_cnt      VGA counters (full resolution)
//   frame_tick        one-clk pulse per video frame
//   isLocked, bump    door lock level, player push pulse
//   pixel_addr        registered sheet address (0 when no hit)
//   isObject          registered "pixel is door" flag
//   busy, frame_idx   animation status
// Optional feature macro: DOOR_BLINK_EN (blink on bump into a locked door).
// Revision: 1.0 - initial animated door release
// ============================================================================
`default_nettype none

module draw_door_anim
  import draw_pkg::*;
#(
  parameter int X0          = 265,
  parameter int Y0          = 125,
  parameter int W           = 10,
  parameter int H           = 10,
  parameter int N_FRAMES    = 4,
  parameter int FRAME_HOLD  = 3,
  parameter int SHEET_W     = 360,
  parameter int SHEET_X0    = 340,
  parameter int SHEET_Y0    = 20,
  parameter int MEM_DEPTH   = 86400,
  parameter int BLINK_TICKS = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [3:0]                  state,
  input  logic [9:0]                  h_cnt,
  input  logic [9:0]                  v_cnt,
  input  logic                        frame_tick,
  input  logic                        isLocked,
  input  logic                        bump,
  output logic [16:0]                 pixel_addr,
  output logic                        isObject,
  output logic                        busy,
  output logic [$clog2(N_FRAMES)-1:0] frame_idx
);

  logic        blank;
  logic [19:0] x20, y20, xo, yo, raw, addr20;
  logic        hit;
  logic [16:0] pixel_addr_d, pixel_addr_q;
  logic        isObject_d, isObject_q;
  logic        lsb_unused;

  door_anim_fsm #(
    .N_FRAMES    (N_FRAMES),
    .FRAME_HOLD  (FRAME_HOLD),
    .BLINK_TICKS (BLINK_TICKS)
  ) u_fsm (
    .clk        (clk),
    .rst        (rst),
    .state      (state),
    .frame_tick (frame_tick),
    .isLocked   (isLocked),
    .bump       (bump),
    .frame_idx  (frame_idx),
    .busy       (busy),
    .blank      (blank)
  );

  // Half-resolution coordinates, widened to the 20-bit address datapath.
  assign x20        = {11'd0, h_cnt[9:1]};
  assign y20        = {11'd0, v_cnt[9:1]};
  assign lsb_unused = h_cnt[0] ^ v_cnt[0];

  assign hit = is_drawable(state)
             && (x20 >= 20'(X0)) && (x20 < 20'(X0 + W))
             && (y20 >= 20'(Y0)) && (y20 < 20'(Y0 + H));

  assign xo     = x20 - 20'(X0);
  assign yo     = y20 - 20'(Y0);
  assign raw    = 20'(SHEET_X0) + (20'(frame_idx) * 20'(W)) + xo
                + ((20'(SHEET_Y0) + yo) * 20'(SHEET_W));
  assign addr20 = raw % 20'(MEM_DEPTH);

  assign pixel_addr_d = hit ? 17'(addr20) : 17'd0;
  assign isObject_d   = hit & ~blank;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pixel_addr_q <= '0;
      isObject_q   <= 1'b0;
    end else begin
      pixel_addr_q <= pixel_addr_d;
      isObject_q   <= isObject_d;
    end
  end

  assign pixel_addr = pixel_addr_q;
  assign isObject   = isObject_q;

endmodule

`default_nettype wire

// File: doc/draw_door_anim.md
# draw_door_anim

Animated, parametrised door-sprite overlay for the VGA renderer. It replaces the static locked/unlocked door icon with a multi-frame open and close animation paced by a per-frame tick. Outputs are registered sprite-sheet addresses plus an object flag, consumed by the pixel mux alongside the other `draw_*` overlays.

## Interface
- `X0`, 265: sprite left edge in half-resolution coordinates.
- `Y0`, 125: sprite top edge in half-resolution coordinates.
- `W`, 10: sprite width in half-resolution pixels.
- `H`, 10: sprite height in half-resolution pixels.
- `N_FRAMES`, 4: animation frames. Frame 0 is fully closed; frame N_FRAMES-1 is fully open.
- `FRAME_HOLD`, 3: frame ticks spent on each intermediate frame.
- `SHEET_W`, 360: sprite-sheet row pitch.
- `SHEET_X0`, 340: sheet column of frame 0. Frame k starts at column SHEET_X0 + k*W.
- `SHEET_Y0`, 20: sheet row of the sprite's top line.
- `MEM_DEPTH`, 86400: sheet memory depth; addresses wrap modulo this value.
- `BLINK_TICKS`, 16: blink duration in frame ticks.
- `clk`  in  1: pixel clock.
- `rst`  in  1: asynchronous, active-high reset.
- `state`  in  4: game state. STAGE1=2, STAGE2=4 and STAGE3=6 are drawable; all other codes are not.
- `h_cnt`, `v_cnt`  in  10 each: VGA counters.
- `frame_tick`  in  1: one-clk pulse per video frame.
- `isLocked`  in  1: door lock level.
- `bump`  in  1: one-clk pulse when the player pushes the door.
- `pixel_addr`  out  17: sheet address.
- `isObject`  out  1: current pixel belongs to the door.
- `busy`  out  1: an animation is in progress.
- `frame_idx`  out  $clog2(N_FRAMES): currently displayed frame.

## Operation
- Coordinates: x = h_cnt>>1, y = v_cnt>>1.
- Hit test: X0 ≤ x < X0+W and Y0 ≤ y < Y0+H, and `state` is drawable.
- Address: (SHEET_X0 + frame_idx*W + (x−X0)) + (SHEET_Y0 + (y−Y0))*SHEET_W, taken modulo MEM_DEPTH.
  - Intermediate arithmetic is 20 bits wide, then truncated to 17.
- When there is no hit: pixel_addr=0 and isObject=0.
- Lock-edge detect uses lk_q, a registered copy of isLocked. lk_q resets to 1.
- FSM states:
  - CLOSED: frame 0.
  - OPENING: frame increments.
  - OPEN: frame N_FRAMES-1.
  - CLOSING: frame decrements.
- FSM transitions:
  - Falling edge of isLocked in CLOSED or CLOSING → OPENING.
  - Rising edge of isLocked in OPEN or OPENING → CLOSING.
  - A reversal mid-animation keeps the current frame_idx and resets the hold counter to 0.
- Stepping: a hold counter counts frame_ticks. When it reaches FRAME_HOLD-1, frame_idx steps and the counter clears.
- OPENING reaching N_FRAMES-1 → OPEN. CLOSING reaching 0 → CLOSED.
- An edge and a frame_tick in the same clk: the edge wins. The tick is not counted.
- Non-drawable state: the FSM snaps to CLOSED with frame 0 if lk_q=1, or to OPEN with frame N_FRAMES-1 if lk_q=0. The hold counter clears and busy=0. On entering a stage, the door therefore never animates spuriously.
- `busy` = 1 in OPENING or CLOSING.

## Timing
- pixel_addr and isObject are registered: they respond to h_cnt/v_cnt with 1-clk latency. The pixel mux delays its other inputs by one clk to match.
- FSM state and frame_idx update on the clk after the triggering edge or tick. The address uses the registered frame_idx.
- Full open takes (N_FRAMES−1)*FRAME_HOLD frame ticks: 9 at the defaults.
- Values after reset: pixel_addr=0, isObject=0, busy=0, frame_idx=0, FSM=CLOSED, hold counter=0, blink counter=0, lk_q=1.
- A reset asserted mid-animation aborts it immediately.

## Configuration
- `DOOR_BLINK_EN` defined:
  - A `bump` in CLOSED with isLocked=1 loads the blink counter with BLINK_TICKS. It decrements once per frame_tick.
  - While the counter ≠ 0 and bit 2 of the counter is 1, isObject is forced to 0. pixel_addr is unchanged.
  - A bump during an active blink reloads the counter.
  - An unlock edge clears the counter.
- `DOOR_BLINK_EN` undefined: `bump` is ignored and the blink counter is not synthesised. The port remains.

## Structure
- Shared package `draw_pkg`: game-state codes (TITLE..FAIL), a drawable-state predicate function, and the FSM state enum.
- Sub-module `door_anim_fsm`: contains edge detect, FSM, hold counter and blink counter. Outputs frame_idx, busy and blank.
- `draw_door_anim` instantiates `door_anim_fsm` and adds the hit test, address generation and output registers.

## Test plan
- Reset, state=2, pixel at x=265, y=125 (h=530, v=250) with isLocked=1 → the next clk gives isObject=1 and pixel_addr=340+20*360=7540.
- isLocked 1→0, then 9 frame_ticks → frame_idx steps 1, 2, 3 after ticks 3, 6 and 9. busy falls with the step to 3. Pixel (265,125) then gives addr 7570.
- isLocked toggles 1→0→1, with the rise arriving after 4 ticks (frame_idx=1) → FSM goes to CLOSING and frame_idx reaches 0 after 3 more ticks.
- Edge and frame_tick in the same clk → the hold counter stays 0, so the first step occurs 3 ticks later.
- state changes 4→5 mid-OPENING, then back to 6 → frame_idx=3 and busy=0. Pixel (274,134) is not a hit while state=5.
- With DOOR_BLINK_EN: bump in CLOSED → isObject is 0 during ticks where the counter is 15..12 and 7..4, and 1 otherwise. Without the macro, bump has no effect.
